// File: rtl/qspi_psram_target.sv
// Quad-mode PSRAM responder: oversamples the QSPI bus on clk and maps
// 0x35/0xEB/0x38/0xF5 transactions onto a synchronous word memory port.
module qspi_psram_target #(
    parameter int ASZ      = 22,
    parameter int DSZ      = 16,
    parameter int RD_LAT   = 2,
    parameter int WAIT_CYC = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           qspi_sck,
    input  logic           qspi_ncs,
    input  logic [3:0]     qspi_data_in,
    output logic [3:0]     qspi_data_out,
    output logic           qspi_data_out_en,
    output logic           quad_mode,
    output logic [ASZ-1:0] mem_addr,
    output logic [DSZ-1:0] mem_wdata,
    output logic           mem_we,
    output logic           mem_re,
    input  logic [DSZ-1:0] mem_rdata
);
    localparam int NIB = DSZ / 4;
    localparam int WSZ = DSZ - 4;

    typedef enum logic [2:0] {
        IDLE, SPI_CMD, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE
    } state_t;

    state_t         state;
    logic [1:0]     sck_s, ncs_s;
    logic [3:0]     d_s0, d_s1;
    logic           sck_d, ncs_d;
    logic [6:0]     cmd;
    logic [ASZ-1:0] addr_sh;
    logic [WSZ-1:0] wshift;
    logic [DSZ-1:0] rbuf, oshift;
    logic [7:0]     cnt;
    logic [3:0]     rd_wait;
    logic           is_read;
    logic           sck_rise, sck_fall, ncs_fall;

    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign ncs_fall = ~ncs_s[1] & ncs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s <= '0; ncs_s <= '0; d_s0 <= '0; d_s1 <= '0;
            sck_d <= 1'b0; ncs_d <= 1'b0;
            state <= IDLE;
            cmd <= '0; addr_sh <= '0; wshift <= '0; rbuf <= '0; oshift <= '0;
            cnt <= '0; rd_wait <= '0; is_read <= 1'b0;
            quad_mode <= 1'b0;
            qspi_data_out <= '0; qspi_data_out_en <= 1'b0;
            mem_addr <= '0; mem_wdata <= '0; mem_we <= 1'b0; mem_re <= 1'b0;
        end else begin
            sck_s <= {sck_s[0], qspi_sck};
            ncs_s <= {ncs_s[0], qspi_ncs};
            d_s0  <= qspi_data_in;
            d_s1  <= d_s0;
            sck_d <= sck_s[1];
            ncs_d <= ncs_s[1];
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            // rd_wait == 1 marks the clk on which mem_rdata is RD_LAT clk past mem_re
            if (rd_wait != 4'd0) rd_wait <= rd_wait - 4'd1;
            if (rd_wait == 4'd1) rbuf <= mem_rdata;
            if (mem_we) mem_addr <= mem_addr + ASZ'(1);

            if (ncs_s[1]) begin
                state <= IDLE;
                qspi_data_out_en <= 1'b0;
                cnt <= '0; cmd <= '0; addr_sh <= '0; wshift <= '0; oshift <= '0;
                rd_wait <= '0;
            end else begin
                case (state)
                    IDLE: if (ncs_fall) begin
                        state <= quad_mode ? CMD : SPI_CMD;
                        cnt <= '0;
                    end
                    SPI_CMD: if (sck_rise) begin
                        cmd <= {cmd[5:0], d_s1[0]};
                        if (cnt == 8'd7) begin
                            if ({cmd, d_s1[0]} == 8'h35) quad_mode <= 1'b1;
                            state <= IGNORE;
                        end else cnt <= cnt + 8'd1;
                    end
                    CMD: if (sck_rise) begin
                        cmd <= {cmd[2:0], d_s1};
                        if (cnt == 8'd1) begin
                            cnt <= '0;
                            case ({cmd[3:0], d_s1})
                                8'hEB: begin is_read <= 1'b1; state <= ADDR; end
                                8'h38: begin is_read <= 1'b0; state <= ADDR; end
                                8'hF5: begin quad_mode <= 1'b0; state <= IGNORE; end
                                default: state <= IGNORE;
                            endcase
                        end else cnt <= cnt + 8'd1;
                    end
                    ADDR: if (sck_rise) begin
                        addr_sh <= ASZ'({addr_sh, d_s1});
                        if (cnt == 8'd5) begin
                            cnt <= '0;
                            mem_addr <= ASZ'({addr_sh, d_s1});
                            if (is_read) begin
                                mem_re  <= 1'b1;
                                rd_wait <= 4'(RD_LAT + 1);
                                state   <= WAIT;
                            end else state <= WDATA;
                        end else cnt <= cnt + 8'd1;
                    end
                    WAIT: if (sck_rise) begin
                        if (cnt == 8'(WAIT_CYC - 1)) begin
                            cnt <= '0;
                            state <= RDATA;
                        end else cnt <= cnt + 8'd1;
                    end
                    RDATA: if (sck_fall) begin
                        qspi_data_out_en <= 1'b1;
                        // cnt == 0 is the first nibble of a word: take it from the read buffer
                        if (cnt == 8'd0) begin
                            qspi_data_out <= rbuf[DSZ-1 -: 4];
                            oshift <= {rbuf[DSZ-5:0], 4'b0};
                        end else begin
                            qspi_data_out <= oshift[DSZ-1 -: 4];
                            oshift <= {oshift[DSZ-5:0], 4'b0};
                        end
                        if (cnt == 8'(NIB - 1)) begin
                            cnt <= '0;
                            mem_addr <= mem_addr + ASZ'(1);
                            mem_re <= 1'b1;
                            rd_wait <= 4'(RD_LAT + 1);
                        end else cnt <= cnt + 8'd1;
                    end
                    WDATA: if (sck_rise) begin
                        wshift <= WSZ'({wshift, d_s1});
                        if (cnt == 8'(NIB - 1)) begin
                            cnt <= '0;
                            mem_wdata <= {wshift, d_s1};
                            mem_we <= 1'b1;
                        end else cnt <= cnt + 8'd1;
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_psram_target.sv
// Scoreboard bench for qspi_psram_target: directed QSPI transactions with
// queued expectations checked by monitors on mem strobes and IO nibbles.
module tb_qspi_psram_target;
    localparam int ASZ = 22, DSZ = 16, RD_LAT = 2, WAIT_CYC = 6;

    logic           clk = 1'b0, reset = 1'b1;
    logic           qspi_sck = 1'b0, qspi_ncs = 1'b1;
    logic [3:0]     qspi_data_in = 4'h0;
    logic [3:0]     qspi_data_out;
    logic           qspi_data_out_en, quad_mode, mem_we, mem_re;
    logic [ASZ-1:0] mem_addr;
    logic [DSZ-1:0] mem_wdata, mem_rdata;

    qspi_psram_target #(.ASZ(ASZ), .DSZ(DSZ), .RD_LAT(RD_LAT), .WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .reset(reset), .qspi_sck(qspi_sck), .qspi_ncs(qspi_ncs),
        .qspi_data_in(qspi_data_in), .qspi_data_out(qspi_data_out),
        .qspi_data_out_en(qspi_data_out_en), .quad_mode(quad_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [ASZ-1:0] addr; logic [DSZ-1:0] data; } wr_t;
    wr_t            exp_wr[$];
    logic [ASZ-1:0] exp_re[$];
    logic [3:0]     exp_nib[$];
    int             checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: data is only valid exactly RD_LAT clk after mem_re
    function automatic logic [DSZ-1:0] mem_val(input logic [ASZ-1:0] a);
        case (a)
            22'h3FFFFF: return 16'hBEEF;
            22'h000000: return 16'h0102;
            22'h000100: return 16'h4321;
            default:    return 16'hDEAD;
        endcase
    endfunction

    logic           pv [1:8];
    logic [ASZ-1:0] pa [1:8];
    initial for (int k = 1; k <= 8; k++) begin pv[k] = 1'b0; pa[k] = '0; end
    always @(posedge clk) begin
        pv[1] <= mem_re;
        pa[1] <= mem_addr;
        for (int k = 2; k <= 8; k++) begin pv[k] <= pv[k-1]; pa[k] <= pa[k-1]; end
    end
    always_comb begin
        mem_rdata = 16'h5A5A;
        if (pv[RD_LAT]) mem_rdata = mem_val(pa[RD_LAT]);
    end

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
        if (mem_re) begin
            if (exp_re.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: addr 0x%0h, expected none", mem_addr);
            end else begin
                logic [ASZ-1:0] a;
                a = exp_re.pop_front();
                check("re_addr", 32'(mem_addr), 32'(a));
            end
        end
    end

    always @(posedge qspi_sck) begin
        if (qspi_data_out_en) begin
            if (exp_nib.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_en: nibble 0x%0h, expected out_en=0", qspi_data_out);
            end else begin
                logic [3:0] n;
                n = exp_nib.pop_front();
                check("rd_nibble", 32'(qspi_data_out), 32'(n));
            end
        end
    end

    task automatic cs_low();
        @(negedge clk);
        qspi_ncs = 1'b0;
        #100;
    endtask
    task automatic cs_high();
        #50 qspi_ncs = 1'b1;
        #200;
    endtask
    task automatic cyc(input logic [3:0] n);
        qspi_data_in = n;
        #50 qspi_sck = 1'b1;
        #50 qspi_sck = 1'b0;
    endtask
    task automatic qbyte(input logic [7:0] b);
        cyc(b[7:4]); cyc(b[3:0]);
    endtask
    task automatic sbyte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
    endtask
    task automatic qaddr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) cyc(a[i*4 +: 4]);
    endtask
    task automatic qword(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) cyc(w[i*4 +: 4]);
    endtask
    task automatic qwrite(input logic [23:0] a, input logic [15:0] w);
        cs_low(); qbyte(8'h38); qaddr(a); qword(w); cs_high();
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_quad_mode"}, 32'(quad_mode), 32'h0);
        check({tag, "_out_en"},    32'(qspi_data_out_en), 32'h0);
        check({tag, "_data_out"},  32'(qspi_data_out), 32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, "_mem_we"},    32'(mem_we), 32'h0);
        check({tag, "_mem_re"},    32'(mem_re), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        cs_low(); sbyte(8'h35); cs_high();
        check("enter_quad", 32'(quad_mode), 32'h1);

        exp_wr.push_back('{addr: 22'h000010, data: 16'hA5C3});
        exp_wr.push_back('{addr: 22'h000011, data: 16'h1234});
        cs_low(); qbyte(8'h38); qaddr(24'h000010); qword(16'hA5C3); qword(16'h1234); cs_high();
        check("write_burst_done", 32'(exp_wr.size()), 32'h0);

        exp_re.push_back(22'h3FFFFF);
        exp_re.push_back(22'h000000);
        exp_re.push_back(22'h000001);
        foreach (exp_wr[i]) ;
        begin
            logic [31:0] nibs;
            nibs = 32'hBEEF0102;
            for (int i = 7; i >= 0; i--) exp_nib.push_back(nibs[i*4 +: 4]);
        end
        cs_low(); qbyte(8'hEB); qaddr(24'h3FFFFF);
        repeat (WAIT_CYC) cyc(4'h0);
        repeat (8) cyc(4'h0);
        cs_high();
        check("read_nibbles_done", 32'(exp_nib.size()), 32'h0);
        check("read_strobes_done", 32'(exp_re.size()), 32'h0);
        check("read_out_en_off", 32'(qspi_data_out_en), 32'h0);

        exp_wr.push_back('{addr: 22'h000020, data: 16'hCAFE});
        cs_low(); qbyte(8'h38); qaddr(24'h000020); qword(16'hCAFE); cyc(4'h7); cyc(4'h7); cs_high();
        check("abort_one_write", 32'(exp_wr.size()), 32'h0);
        exp_wr.push_back('{addr: 22'h000030, data: 16'h1357});
        qwrite(24'h000030, 16'h1357);
        check("after_abort_write", 32'(exp_wr.size()), 32'h0);

        cs_low(); qbyte(8'h9F); repeat (4) cyc(4'hA); cs_high();
        check("unknown_keeps_quad", 32'(quad_mode), 32'h1);
        check("unknown_out_en", 32'(qspi_data_out_en), 32'h0);
        cs_low(); qbyte(8'hF5); cs_high();
        check("exit_quad", 32'(quad_mode), 32'h0);

        cs_low(); sbyte(8'h35); cs_high();
        check("reenter_quad", 32'(quad_mode), 32'h1);
        exp_re.push_back(22'h000100);
        exp_nib.push_back(4'h4);
        exp_nib.push_back(4'h3);
        cs_low(); qbyte(8'hEB); qaddr(24'h000100);
        repeat (WAIT_CYC) cyc(4'h0);
        repeat (2) cyc(4'h0);
        check("mid_read_addr", 32'(mem_addr), 32'h100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        qspi_ncs = 1'b1;
        #200;
        check("mid_read_nibbles", 32'(exp_nib.size()), 32'h0);

        qwrite(24'h000040, 16'hFFFF);
        check("spi_mode_after_reset", 32'(quad_mode), 32'h0);
        cs_low(); sbyte(8'h35); cs_high();
        check("quad_after_reset", 32'(quad_mode), 32'h1);
        exp_wr.push_back('{addr: 22'h000040, data: 16'h9876});
        qwrite(24'h000040, 16'h9876);

        repeat (10) @(negedge clk);
        check("final_wr_queue", 32'(exp_wr.size()), 32'h0);
        check("final_re_queue", 32'(exp_re.size()), 32'h0);
        check("final_nib_queue", 32'(exp_nib.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
